// File: rtl/stream_grant_mux_pkg.sv
// Shared types and helpers for stream_grant_mux.
// beat_t is sized for the widest supported configuration; users slice what they need.
package stream_grant_mux_pkg;

    localparam int unsigned MaxDataWidth = 64;
    localparam int unsigned MaxIdxWidth  = 8;

    function automatic int unsigned idx_width(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    typedef struct packed {
        logic [MaxDataWidth-1:0] data;
        logic                    last;
        logic [MaxIdxWidth-1:0]  tid;
    } beat_t;

endpackage

// File: rtl/stream_grant_mux_if.sv
// Bus bundle for stream_grant_mux: input streams, merged output stream, arbiter handshake.
// m_tid exists only when STREAM_GRANT_MUX_TID_EN is defined.
interface stream_grant_mux_if #(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    import stream_grant_mux_pkg::*;

    localparam int unsigned IdxWidth = idx_width(PORTS);

    logic [PORTS*DATA_WIDTH-1:0] s_tdata;
    logic [PORTS-1:0]            s_tvalid;
    logic [PORTS-1:0]            s_tready;
    logic [PORTS-1:0]            s_tlast;
    logic [DATA_WIDTH-1:0]       m_tdata;
    logic                        m_tvalid;
    logic                        m_tready;
    logic                        m_tlast;
`ifdef STREAM_GRANT_MUX_TID_EN
    logic [IdxWidth-1:0]         m_tid;
`endif
    logic [PORTS-1:0]            arb_request;
    logic [PORTS-1:0]            arb_acknowledge;
    logic [PORTS-1:0]            arb_grant;
    logic                        arb_grant_valid;
    logic [IdxWidth-1:0]         arb_grant_encoded;

`ifdef STREAM_GRANT_MUX_TID_EN
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        output arb_grant, arb_grant_valid, arb_grant_encoded,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid, arb_request, arb_acknowledge
    );
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        input  arb_grant, arb_grant_valid, arb_grant_encoded,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tid, arb_request, arb_acknowledge
    );
`else
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        output arb_grant, arb_grant_valid, arb_grant_encoded,
        input  s_tready, m_tdata, m_tvalid, m_tlast, arb_request, arb_acknowledge
    );
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        input  arb_grant, arb_grant_valid, arb_grant_encoded,
        output s_tready, m_tdata, m_tvalid, m_tlast, arb_request, arb_acknowledge
    );
`endif

endinterface

// File: rtl/stream_skid_reg.sv
// Two-entry valid/ready register slice (output register plus skid entry).
// in_ready is registered: it only reflects whether the skid entry is free.
module stream_skid_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             accept;

    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid & in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (out_ready || !out_valid_q) begin
            // Skid beat is older than anything arriving, so it drains first.
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = in_data;
                end
            end
        end else if (accept) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/stream_grant_mux.sv
// Frame-granular stream mux following an external blocking round-robin arbiter's grant.
// Define STREAM_GRANT_MUX_TID_EN to add m_tid, the source port index of each output beat.
module stream_grant_mux
    import stream_grant_mux_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    stream_grant_mux_if.slave bus
);

    localparam int unsigned IdxWidth = idx_width(PORTS);
`ifdef STREAM_GRANT_MUX_TID_EN
    localparam int unsigned PayloadWidth = DATA_WIDTH + 1 + IdxWidth;
`else
    localparam int unsigned PayloadWidth = DATA_WIDTH + 1;
`endif

    logic                    int_ready;
    logic [PORTS-1:0]        s_tready;
    beat_t                   sel_beat;
    logic                    sel_valid;
    logic [PayloadWidth-1:0] in_payload;
    logic [PayloadWidth-1:0] out_payload;
    logic                    unused_sel_bits;

    assign bus.arb_request     = bus.s_tvalid;
    assign s_tready            = {PORTS{bus.arb_grant_valid & int_ready}} & bus.arb_grant;
    assign bus.s_tready        = s_tready;
    assign bus.arb_acknowledge = bus.arb_grant & bus.s_tvalid & s_tready & bus.s_tlast;

    // Compare against each index so an out-of-range encoded grant selects nothing.
    always_comb begin
        sel_beat  = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (bus.arb_grant_encoded == IdxWidth'(i)) begin
                sel_beat.data[DATA_WIDTH-1:0] = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_beat.last                 = bus.s_tlast[i];
                sel_beat.tid[IdxWidth-1:0]    = IdxWidth'(i);
                sel_valid                     = bus.s_tvalid[i] & s_tready[i];
            end
        end
    end

    // Padding bits of the shared beat type never reach the registers.
    assign unused_sel_bits = ^sel_beat;

`ifdef STREAM_GRANT_MUX_TID_EN
    assign in_payload = {sel_beat.data[DATA_WIDTH-1:0], sel_beat.last,
                         sel_beat.tid[IdxWidth-1:0]};
    assign {bus.m_tdata, bus.m_tlast, bus.m_tid} = out_payload;
`else
    assign in_payload = {sel_beat.data[DATA_WIDTH-1:0], sel_beat.last};
    assign {bus.m_tdata, bus.m_tlast} = out_payload;
`endif

    stream_skid_reg #(
        .WIDTH (PayloadWidth)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_payload),
        .in_valid  (sel_valid),
        .in_ready  (int_ready),
        .out_data  (out_payload),
        .out_valid (bus.m_tvalid),
        .out_ready (bus.m_tready)
    );

endmodule

// File: tb/tb_stream_grant_mux.sv
// Bench for stream_grant_mux: combinational vector table, then frame sequences checked
// against a scoreboard, with a behavioural blocking round-robin arbiter in the loop.
module tb_stream_grant_mux;

    localparam int P  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stream_grant_mux_if #(.PORTS(P), .DATA_WIDTH(W)) bus ();

    stream_grant_mux #(.PORTS(P), .DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         bubble;
        logic [W-1:0] data;
        bit         last;
    } item_t;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          last;
        logic [IW-1:0] tid;
    } exp_t;

    typedef struct {
        logic        gv;
        logic [3:0]  g;
        logic [1:0]  e;
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [31:0] td;
        logic [3:0]  rdy;
        logic [3:0]  ack;
        logic        mv;
        logic [7:0]  md;
        logic        ml;
    } vec_t;

    item_t        srcq [P][$];
    bit           rdyq[$];
    exp_t         sb[$];
    logic [W-1:0] outlog[$];

    logic [P-1:0]  g_grant;
    bit            g_valid;
    logic [IW-1:0] g_enc;
    int            rr_last;

    int cyc, first_mvalid, last_out, max_held;
    int first_fire[P], ack_step[P], ack_cnt[P], fire_cnt[P];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at step %0d", name, cyc);
    endtask

    task automatic push(int p, logic [W-1:0] d, bit l);
        srcq[p].push_back('{bubble: 1'b0, data: d, last: l});
    endtask

    task automatic push_bubble(int p);
        srcq[p].push_back('{bubble: 1'b1, data: '0, last: 1'b0});
    endtask

    task automatic clear_drive();
        bus.s_tdata           = '0;
        bus.s_tvalid          = '0;
        bus.s_tlast           = '0;
        bus.m_tready          = 1'b1;
        bus.arb_grant         = '0;
        bus.arb_grant_valid   = 1'b0;
        bus.arb_grant_encoded = '0;
    endtask

    task automatic init_test();
        cyc          = 0;
        first_mvalid = -1;
        last_out     = -1;
        max_held     = 0;
        outlog.delete();
        for (int i = 0; i < P; i++) begin
            first_fire[i] = -1;
            ack_step[i]   = -1;
            ack_cnt[i]    = 0;
            fire_cnt[i]   = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_drive();
        for (int i = 0; i < P; i++) srcq[i].delete();
        rdyq.delete();
        sb.delete();
        g_valid = 1'b0;
        g_grant = '0;
        g_enc   = '0;
        rr_last = P - 1;
        #1;
        check("rst_async_m_tvalid", bus.m_tvalid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_m_tvalid", bus.m_tvalid, 0);
        check("rst_m_tdata", bus.m_tdata, 0);
        check("rst_m_tlast", bus.m_tlast, 0);
        check("rst_s_tready", bus.s_tready, 0);
        check("rst_arb_acknowledge", bus.arb_acknowledge, 0);
    endtask

    // One clock: drive at negedge, check and model after settling, advance after posedge.
    task automatic step();
        logic [P*W-1:0] td;
        logic [P-1:0]   tv, tl, fire, exp_rdy, n_grant;
        bit             mr, n_valid;
        logic [IW-1:0]  n_enc;
        int             held, n_last;
        exp_t           e;
        td = '0;
        tv = '0;
        tl = '0;
        for (int i = 0; i < P; i++) begin
            if (srcq[i].size() > 0 && !srcq[i][0].bubble) begin
                tv[i]         = 1'b1;
                tl[i]         = srcq[i][0].last;
                td[i*W +: W]  = srcq[i][0].data;
            end
        end
        mr                    = (rdyq.size() > 0) ? rdyq[0] : 1'b1;
        bus.s_tdata           = td;
        bus.s_tvalid          = tv;
        bus.s_tlast           = tl;
        bus.m_tready          = mr;
        bus.arb_grant         = g_grant;
        bus.arb_grant_valid   = g_valid;
        bus.arb_grant_encoded = g_enc;
        #1;
        held = sb.size();
        if (held > max_held) max_held = held;
        if (held >= 2) check("beats_held", held, 2);
        exp_rdy = (g_valid && held < 2) ? g_grant : '0;
        check("s_tready", bus.s_tready, exp_rdy);
        check("arb_request", bus.arb_request, tv);
        fire = tv & exp_rdy;
        check("arb_acknowledge", bus.arb_acknowledge, fire & tl);
        check("m_tvalid", bus.m_tvalid, held > 0);
        if (bus.m_tvalid === 1'b1 && mr && sb.size() > 0) begin
            e = sb.pop_front();
            check("m_tdata", bus.m_tdata, e.data);
            check("m_tlast", bus.m_tlast, e.last);
`ifdef STREAM_GRANT_MUX_TID_EN
            check("m_tid", bus.m_tid, e.tid);
`endif
            outlog.push_back(bus.m_tdata);
            last_out = cyc;
        end
        if (bus.m_tvalid === 1'b1 && first_mvalid < 0) first_mvalid = cyc;
        for (int i = 0; i < P; i++) begin
            if (fire[i]) begin
                sb.push_back('{data: td[i*W +: W], last: tl[i], tid: IW'(i)});
                if (first_fire[i] < 0) first_fire[i] = cyc;
                fire_cnt[i]++;
            end
            if (bus.arb_acknowledge[i] === 1'b1) begin
                ack_step[i] = cyc;
                ack_cnt[i]++;
            end
        end
        // Blocking round-robin arbiter: hold grant until its port acknowledges.
        n_valid = g_valid;
        n_grant = g_grant;
        n_enc   = g_enc;
        n_last  = rr_last;
        if (!(g_valid && ((bus.arb_acknowledge & g_grant) == '0))) begin
            n_valid = 1'b0;
            n_grant = '0;
            n_enc   = '0;
            for (int k = 1; k <= P; k++) begin
                int idx;
                idx = (rr_last + k) % P;
                if (!n_valid && bus.arb_request[idx] === 1'b1) begin
                    n_valid = 1'b1;
                    n_grant = P'(1 << idx);
                    n_enc   = IW'(idx);
                    n_last  = idx;
                end
            end
        end
        @(posedge clk);
        for (int i = 0; i < P; i++) begin
            if (srcq[i].size() > 0 && (srcq[i][0].bubble || fire[i])) void'(srcq[i].pop_front());
        end
        if (rdyq.size() > 0) void'(rdyq.pop_front());
        g_valid = n_valid;
        g_grant = n_grant;
        g_enc   = n_enc;
        rr_last = n_last;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_done(string name, int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            step();
            n++;
            busy = (sb.size() > 0);
            for (int i = 0; i < P; i++) if (srcq[i].size() > 0) busy = 1'b1;
        end
        if (busy) fail_now(name);
    endtask

    task automatic check_seq(string name, input logic [W-1:0] exp_q[$]);
        check({name, "_len"}, outlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < outlog.size(); i++) begin
            check(name, outlog[i], exp_q[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] eq[$];
        int           n;

        do_reset();

        // gv grant enc tvalid tlast tdata -> s_tready ack, next m_tvalid m_tdata m_tlast
        vecs[0] = '{1'b0, 4'b0001, 2'd0, 4'b1111, 4'b1111, 32'hD4C3B2A1, 4'b0000, 4'b0000,
                    1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 4'b0000, 2'd0, 4'b0101, 4'b0000, 32'h11111111, 4'b0000, 4'b0000,
                    1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 4'b0010, 2'd1, 4'b0010, 4'b0000, 32'h00005A00, 4'b0010, 4'b0000,
                    1'b1, 8'h5A, 1'b0};
        vecs[3] = '{1'b1, 4'b0010, 2'd1, 4'b0011, 4'b0010, 32'h0000A5FF, 4'b0010, 4'b0010,
                    1'b1, 8'hA5, 1'b1};
        vecs[4] = '{1'b1, 4'b0100, 2'd2, 4'b1011, 4'b1111, 32'h77665544, 4'b0100, 4'b0000,
                    1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 4'b1000, 2'd3, 4'b1000, 4'b1000, 32'hC3000000, 4'b1000, 4'b1000,
                    1'b1, 8'hC3, 1'b1};
        vecs[6] = '{1'b1, 4'b0001, 2'd0, 4'b0000, 4'b0001, 32'h00000011, 4'b0001, 4'b0000,
                    1'b0, 8'h00, 1'b0};
        vecs[7] = '{1'b1, 4'b0001, 2'd0, 4'b0001, 4'b0000, 32'h0000003C, 4'b0001, 4'b0000,
                    1'b1, 8'h3C, 1'b0};
        for (int v = 0; v < 8; v++) begin
            bus.arb_grant_valid   = vecs[v].gv;
            bus.arb_grant         = vecs[v].g;
            bus.arb_grant_encoded = vecs[v].e;
            bus.s_tvalid          = vecs[v].tv;
            bus.s_tlast           = vecs[v].tl;
            bus.s_tdata           = vecs[v].td;
            bus.m_tready          = 1'b1;
            #1;
            check("vec_s_tready", bus.s_tready, vecs[v].rdy);
            check("vec_arb_acknowledge", bus.arb_acknowledge, vecs[v].ack);
            check("vec_arb_request", bus.arb_request, vecs[v].tv);
            @(posedge clk);
            #1;
            check("vec_m_tvalid", bus.m_tvalid, vecs[v].mv);
            if (vecs[v].mv) begin
                check("vec_m_tdata", bus.m_tdata, vecs[v].md);
                check("vec_m_tlast", bus.m_tlast, vecs[v].ml);
            end
            @(negedge clk);
        end

        // Single port, three beats: latency and acknowledge timing.
        do_reset();
        init_test();
        push(0, 8'hA1, 0);
        push(0, 8'hA2, 0);
        push(0, 8'hA3, 1);
        run_until_done("single_port", 40);
        eq = '{8'hA1, 8'hA2, 8'hA3};
        check_seq("single_port_order", eq);
        check("single_first_m_tvalid_cycle", first_mvalid, 2);
        check("single_ack_cycle", ack_step[0], 3);
        check("single_ack_pulses", ack_cnt[0], 1);
        check("single_last_out_cycle", last_out, 4);

        // Ports 1 and 2 contend: whole frames, back to back.
        do_reset();
        init_test();
        push(1, 8'hB0, 0);
        push(1, 8'hB1, 1);
        push(2, 8'hC0, 0);
        push(2, 8'hC1, 1);
        run_until_done("contend", 40);
        eq = '{8'hB0, 8'hB1, 8'hC0, 8'hC1};
        check_seq("contend_order", eq);
        check("contend_first_out", first_mvalid, 2);
        check("contend_no_idle", last_out, 5);
        check("contend_p2_after_ack", first_fire[2], ack_step[1] + 1);

        // Backpressure with toggling m_tready.
        do_reset();
        init_test();
        push(0, 8'hD0, 0);
        push(0, 8'hD1, 0);
        push(0, 8'hD2, 0);
        push(0, 8'hD3, 1);
        rdyq = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1};
        run_until_done("backpressure", 60);
        eq = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        check_seq("backpressure_order", eq);
        check("backpressure_skid_used", max_held, 2);

        // Granted port stalls mid-frame while port 3 waits.
        do_reset();
        init_test();
        push(1, 8'hE0, 0);
        push(1, 8'hE1, 0);
        push_bubble(1);
        push_bubble(1);
        push_bubble(1);
        push(1, 8'hE2, 0);
        push(1, 8'hE3, 1);
        push(3, 8'hF0, 0);
        push(3, 8'hF1, 1);
        run_until_done("stall", 60);
        eq = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hF0, 8'hF1};
        check_seq("stall_order", eq);
        check("stall_p1_ack_cycle", ack_step[1], 7);
        check("stall_p3_waits", first_fire[3] > ack_step[1], 1);

        // Reset after two of five beats, then a clean frame.
        do_reset();
        init_test();
        for (int i = 0; i < 5; i++) push(0, W'(8'h90 + i), i == 4);
        n = 0;
        while (fire_cnt[0] < 2 && n < 20) begin
            step();
            n++;
        end
        if (fire_cnt[0] < 2) fail_now("midreset_prefix");
        do_reset();
        init_test();
        push(2, 8'h61, 0);
        push(2, 8'h62, 0);
        push(2, 8'h63, 1);
        run_until_done("midreset_clean", 40);
        eq = '{8'h61, 8'h62, 8'h63};
        check_seq("midreset_clean_order", eq);
        check("midreset_first_out", first_mvalid, 2);

        // Single-beat frames on ports 0 and 3 (m_tid checked by the scoreboard when present).
        do_reset();
        init_test();
        push(0, 8'h5E, 1);
        push(3, 8'h3E, 1);
        run_until_done("single_beat", 40);
        eq = '{8'h5E, 8'h3E};
        check_seq("single_beat_order", eq);
        check("single_beat_ack_p0", ack_step[0], first_fire[0]);
        check("single_beat_ack_p3", ack_step[3], first_fire[3]);
        check("single_beat_p3_cycle", first_fire[3], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
